// File: rtl/led_link_pkg.sv
// led_link_pkg: shared constants and state encoding
// for the LED-matrix serial link.
package led_link_pkg;

  localparam int NLEDS          = 64;
  localparam int DEF_CLK_DIV    = 4;
  localparam int DEF_STROBE_LEN = 2;

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH,
    STROBE
  } link_state_t;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/led_link_phase_timer.sv
// led_link_phase_timer: loadable down-counter that flags
// the last cycle of a LOW, HIGH or STROBE phase.
module led_link_phase_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] len_i,
  output logic         phase_end_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Parks at zero between frames so phase_end stays low in IDLE.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = len_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign phase_end_o = (cnt_q == W'(1));

endmodule

// File: rtl/led_frame_serializer.sv
// led_frame_serializer: shifts a frame out MSB-first on
// din/dclk and closes it with a strobe latch pulse.
module led_frame_serializer
  import led_link_pkg::*;
#(
  parameter int NBITS      = NLEDS,
  parameter int CLK_DIV    = DEF_CLK_DIV,
  parameter int STROBE_LEN = DEF_STROBE_LEN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NBITS-1:0] frame_data,
  input  logic             frame_valid,
  output logic             frame_ready,
  output logic             busy,
  output logic             frame_done,
  output logic             din,
  output logic             dclk,
  output logic             strobe
);

  localparam int BW = $clog2(NBITS);
  localparam int DW = $clog2(imax(CLK_DIV, STROBE_LEN) + 1);

  localparam logic [BW-1:0] LAST    = BW'(NBITS - 1);
  localparam logic [DW-1:0] DIV_LEN = DW'(CLK_DIV);
  localparam logic [DW-1:0] STB_LEN = DW'(STROBE_LEN);

  link_state_t      state_q;
  logic [NBITS-1:0] sh_q;
  logic [NBITS-1:0] sh_d;
  logic [BW-1:0]    bit_cnt_q;

  logic          accept;
  logic          phase_end;
  logic          ld;
  logic [DW-1:0] ld_len;

  assign accept = frame_valid & frame_ready;
  assign sh_d   = sh_q << 1;

  // Timer reload accompanies every state entry.
  always_comb begin
    ld     = 1'b0;
    ld_len = DIV_LEN;
    unique case (state_q)
      IDLE:   ld = accept;
      LOW:    ld = phase_end;
      HIGH: begin
        ld = phase_end;
        if (bit_cnt_q == LAST) begin
          ld_len = STB_LEN;
        end
      end
      STROBE: ld = 1'b0;
      default: ld = 1'b0;
    endcase
  end

  led_link_phase_timer #(
    .W (DW)
  ) u_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (ld),
    .len_i       (ld_len),
    .phase_end_o (phase_end)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sh_q        <= '0;
      bit_cnt_q   <= '0;
      frame_ready <= 1'b1;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      din         <= 1'b0;
      dclk        <= 1'b0;
      strobe      <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            sh_q        <= frame_data;
            din         <= frame_data[NBITS-1];
            bit_cnt_q   <= '0;
            frame_ready <= 1'b0;
            busy        <= 1'b1;
            state_q     <= LOW;
          end
        end
        LOW: begin
          if (phase_end) begin
            dclk    <= 1'b1;
            state_q <= HIGH;
          end
        end
        HIGH: begin
          if (phase_end) begin
            dclk <= 1'b0;
            if (bit_cnt_q == LAST) begin
              din     <= 1'b0;
              strobe  <= 1'b1;
              state_q <= STROBE;
            end else begin
              sh_q      <= sh_d;
              din       <= sh_d[NBITS-1];
              bit_cnt_q <= bit_cnt_q + 1'b1;
              state_q   <= LOW;
            end
          end
        end
        STROBE: begin
          if (phase_end) begin
            strobe      <= 1'b0;
            frame_done  <= 1'b1;
            busy        <= 1'b0;
            frame_ready <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led_frame_serializer.sv
// tb_led_frame_serializer: scoreboard bench for the default
// link timing and the CLK_DIV=1/STROBE_LEN=1 corner.
`timescale 1ns/1ps
module tb_led_frame_serializer;
  import led_link_pkg::*;

  localparam int NB = 64;

  typedef struct {
    logic [63:0] data;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] fd0 = '0;
  logic [63:0] fd1 = '0;
  logic        fv0 = 1'b0;
  logic        fv1 = 1'b0;
  logic rdy0, bsy0, done0, din0, dclk0, stb0;
  logic rdy1, bsy1, done1, din1, dclk1, stb1;

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  exp_t q0[$];
  exp_t q1[$];

  logic [63:0] chain [2];
  int          nr [2];
  int          rises [2];
  logic        pd [2];
  logic        ps [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  led_frame_serializer u_dut0 (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_data  (fd0),
    .frame_valid (fv0),
    .frame_ready (rdy0),
    .busy        (bsy0),
    .frame_done  (done0),
    .din         (din0),
    .dclk        (dclk0),
    .strobe      (stb0)
  );

  led_frame_serializer #(
    .NBITS      (NB),
    .CLK_DIV    (1),
    .STROBE_LEN (1)
  ) u_dut1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_data  (fd1),
    .frame_valid (fv1),
    .frame_ready (rdy1),
    .busy        (bsy1),
    .frame_done  (done1),
    .din         (din1),
    .dclk        (dclk1),
    .strobe      (stb1)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)",
               nm, act, req, cyc);
    end
  endtask

  // {ready, busy, done, din, dclk, strobe}
  function automatic logic [5:0] outs(input int d);
    if (d == 0) return {rdy0, bsy0, done0, din0, dclk0, stb0};
    return {rdy1, bsy1, done1, din1, dclk1, stb1};
  endfunction

  function automatic logic rdy(input int d);
    return (d == 0) ? rdy0 : rdy1;
  endfunction

  function automatic int qs(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Reference: link waveform as a function of time since acceptance.
  task automatic mon(input int d);
    int cd, per, t, k;
    logic has;
    exp_t e;
    logic [5:0] o, ex;
    cd  = (d == 0) ? DEF_CLK_DIV : 1;
    per = 2 * NB * cd + ((d == 0) ? DEF_STROBE_LEN : 1);
    has = (qs(d) > 0);
    e.data = '0;
    e.acc  = 0;
    if (has) begin
      if (d == 0) e = q0[0];
      else        e = q1[0];
    end
    t  = has ? (cyc - e.acc) : -1;
    o  = outs(d);
    ex = 6'b100000;
    if (has && t >= 0 && t < per) begin
      ex[5] = 1'b0;
      ex[4] = 1'b1;
      if (t < 2 * NB * cd) begin
        k     = NB - 1 - t / (2 * cd);
        ex[2] = e.data[k];
        ex[1] = ((t / cd) % 2) == 1;
      end else begin
        ex[0] = 1'b1;
      end
    end else if (has && t == per) begin
      ex[3] = 1'b1;
    end
    chk((d == 0) ? "link0" : "link1", 64'(o), 64'(ex));

    if (!rst_n) begin
      nr[d]    = 0;
      chain[d] = '0;
    end else begin
      if (o[1] && !pd[d]) begin
        chain[d] = {chain[d][62:0], o[2]};
        nr[d]++;
        rises[d]++;
      end
      if (o[0] && !ps[d] && has) begin
        chk("bits_per_frame", 64'(nr[d]), 64'(NB));
        chk("display", chain[d], e.data);
        nr[d] = 0;
      end
    end
    pd[d] = o[1];
    ps[d] = o[0];
    if (has && t == per) begin
      if (d == 0) void'(q0.pop_front());
      else        void'(q1.pop_front());
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) mon(d);
  end

  task automatic drive(input int d, input logic v, input logic [63:0] x);
    if (d == 0) begin
      fv0 = v;
      fd0 = x;
    end else begin
      fv1 = v;
      fd1 = x;
    end
  endtask

  // Holds valid with junk data until ready, then presents x.
  task automatic send(input int d, input logic [63:0] x, output int acc);
    int w;
    exp_t e;
    w = 0;
    @(negedge clk);
    while (!rdy(d) && w < 3000) begin
      drive(d, 1'b1, rnd64());
      @(negedge clk);
      w++;
    end
    chk("ready_wait", 64'(w < 3000), 64'd1);
    drive(d, 1'b1, x);
    e.data = x;
    e.acc  = cyc + 1;
    acc    = e.acc;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic stop(input int d);
    @(negedge clk);
    drive(d, 1'b0, rnd64());
  endtask

  task automatic wait_done(input int d);
    int w;
    w = 0;
    while (qs(d) != 0 && w < 3000) begin
      @(negedge clk);
      w++;
    end
    chk("drain", 64'(w < 3000), 64'd1);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a1, a2;
    for (int d = 0; d < 2; d++) begin
      chain[d] = '0;
      nr[d]    = 0;
      rises[d] = 0;
      pd[d]    = 1'b0;
      ps[d]    = 1'b0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outs0", 64'(outs(0)), 64'h20);
    chk("reset_outs1", 64'(outs(1)), 64'h20);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    chk("idle_rises", 64'(rises[0] + rises[1]), 64'd0);

    send(0, 64'hA5A5_0000_FFFF_0123, a1);
    stop(0);
    wait_done(0);

    send(0, 64'h8000_0000_0000_0001, a1);
    send(0, rnd64(), a2);
    stop(0);
    chk("b2b_period", 64'(a2 - a1), 64'd515);
    wait_done(0);

    send(1, 64'hFFFF_FFFF_FFFF_FFFF, a1);
    send(1, rnd64(), a2);
    stop(1);
    chk("corner_period", 64'(a2 - a1), 64'd130);
    wait_done(1);

    for (int i = 0; i < 3; i++) begin
      send(0, rnd64(), a1);
      stop(0);
      repeat ($urandom_range(0, 20)) @(negedge clk);
    end
    wait_done(0);

    // Drop the link into reset just after bit 20 has been clocked.
    send(0, rnd64(), a1);
    stop(0);
    repeat (166) @(negedge clk);
    chk("bits_before_reset", 64'(nr[0]), 64'd21);
    #2;
    q0.delete();
    rst_n = 1'b0;
    #1;
    chk("async_reset", 64'(outs(0)), 64'h20);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b1;
    repeat (600) @(negedge clk);
    send(0, rnd64(), a1);
    stop(0);
    wait_done(0);
    wait_done(1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/led_frame_serializer.md
# led_frame_serializer

Transmit side of the LED-matrix serial link. Accepts a 64-bit frame over a valid/ready handshake and emits it on the three-wire link (`din`, `dclk`, `strobe`) that feeds the matrix driver's shift chain and display buffer. Sits between the frame source (pattern generator or host interface) and the driver's `ui_in[0..2]` pins. Timing is generated entirely from the system clock through a programmable divider.

## Interface
- `NBITS`, 64: bits per frame, equal to the matrix LED count.
- `CLK_DIV`, 4: `dclk` half-period in `clk` cycles; legal values are 1 and above.
- `STROBE_LEN`, 2: `strobe` high time in `clk` cycles; legal values are 1 and above.

Ports:
- `clk` input 1: the only clock.
- `rst_n` input 1: reset, asynchronous assert, active-low.
- `frame_data` input NBITS: frame to send; bit NBITS-1 is transmitted first.
- `frame_valid` input 1: source has a frame.
- `frame_ready` output 1: block is in IDLE and can accept a frame.
- `busy` output 1: frame in flight, high in the LOW, HIGH and STROBE states.
- `frame_done` output 1: one-cycle pulse on the cycle `strobe` falls.
- `din` output 1: serial data.
- `dclk` output 1: data clock; the receiver samples `din` on the rising edge.
- `strobe` output 1: latch pulse; the receiver copies its chain on the rising edge.

## Operation
- FSM states: IDLE, LOW, HIGH, STROBE. All link outputs are registered and glitch-free.
- **IDLE**
  - `frame_ready`=1, `dclk`=0, `strobe`=0, `din`=0.
  - On `frame_valid & frame_ready`, capture `frame_data` into the shift register, drive `din` with `frame_data[NBITS-1]`, clear `bit_cnt` and `div_cnt`, and go to LOW.
- **LOW**
  - `dclk`=0 for CLK_DIV cycles, then go to HIGH.
- **HIGH**
  - `dclk`=1 for CLK_DIV cycles.
  - At the end of the phase, if `bit_cnt`==NBITS-1, go to STROBE and set `din` to 0.
  - Otherwise shift left, drive `din` with the next bit, increment `bit_cnt`, and go to LOW.
  - `din` changes only on the same edge that drops `dclk`, so setup and hold are each CLK_DIV cycles.
- **STROBE**
  - `dclk`=0 and `strobe`=1 for STROBE_LEN cycles.
  - On the last cycle, pulse `frame_done` and return to IDLE.
- Counter widths:
  - `bit_cnt` is $clog2(NBITS) bits.
  - `div_cnt` is $clog2(max(CLK_DIV, STROBE_LEN)+1) bits.
  - Neither counter wraps; each is cleared on every state entry.
- `frame_valid` outside IDLE is ignored and `frame_data` is not re-sampled. A source holding valid gets its next frame accepted on the first IDLE cycle.
- There is no back-to-back bypass: at least one IDLE cycle separates frames.

## Timing
- Reset values: state=IDLE, `frame_ready`=1, `busy`=0, `frame_done`=0, `din`=0, `dclk`=0, `strobe`=0, shift register=0.
- Reset mid-frame forces all link outputs low immediately, without waiting for a clock. The partial frame is dropped, and because `strobe` never rises the receiver does not latch it.
- Let edge 0 be the acceptance edge.
  - First `dclk` rise is at edge CLK_DIV.
  - Bit k's rising edge is at edge (2k+1)·CLK_DIV.
  - `strobe` rises at edge 2·NBITS·CLK_DIV and falls at edge 2·NBITS·CLK_DIV+STROBE_LEN.
  - `frame_ready` returns on that same edge.
- Frame period with back-to-back frames is 2·NBITS·CLK_DIV+STROBE_LEN+1 cycles. With defaults that is 515.
- `dclk` is low whenever `strobe` is high and in IDLE.

## Structure
- Shared package `led_link_pkg` holds:
  - `NLEDS`=64;
  - the state enum `link_state_t` (IDLE, LOW, HIGH, STROBE);
  - default CLK_DIV and STROBE_LEN constants, shared with the driver bench.
- One natural sub-module, `led_link_phase_timer`. It is loadable with a phase length, counts down, and asserts `phase_end`. The FSM reuses it for the LOW, HIGH and STROBE phases.

## Test plan
- **Reset values:** release `rst_n` → `frame_ready`=1 and all link outputs 0. Hold `frame_valid`=0 for 100 cycles → no `dclk` edge.
- **Single frame, defaults:** send 64'hA5A5_0000_FFFF_0123 → 64 `dclk` rises, the first at edge 4. `din` sampled at the rises reproduces the frame MSB-first. `strobe` is high over edges 512–514, then `frame_done` pulses once.
- **End-to-end:** drive the matrix driver with the link and send 64'h8000_0000_0000_0001 → driver display buffer equals that value after `strobe`, with bit order matched.
- **Back-to-back:** hold `frame_valid` high with two frames → second acceptance 515 cycles after the first, and `frame_data` changes while busy have no effect.
- **Parameter corner:** CLK_DIV=1, STROBE_LEN=1, frame 64'hFFFF_FFFF_FFFF_FFFF → `dclk` toggles every cycle, 64 rises, frame period 130.
- **Reset mid-frame:** assert `rst_n` low after bit 20 → outputs 0 asynchronously and no `strobe`. The next frame after release transmits cleanly from bit 63.
